// File: rtl/vga_timing_if.sv
// Timing bundle handed from the VGA timing stage to the colour stage.
interface vga_timing_if #(
    parameter int CW = 10
);
    logic          clk_en_25MHz;
    logic          h_sync;
    logic          v_sync;
    logic          video_on;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          line_start;
    logic          frame_start;

    modport master (
        output clk_en_25MHz, h_sync, v_sync, video_on,
        output pixel_x, pixel_y, line_start, frame_start
    );

    modport slave (
        input clk_en_25MHz, h_sync, v_sync, video_on,
        input pixel_x, pixel_y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: 25 MHz pixel enable from 50 MHz clk, h/v counters,
// sync, active-video and coordinates, all decoded from the same counter state.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = 10
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master vga
);
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_LO = H_ACTIVE + H_FP;
    localparam int H_SYNC_HI = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int V_SYNC_LO = V_ACTIVE + V_FP;
    localparam int V_SYNC_HI = V_ACTIVE + V_FP + V_SYNC - 1;

    logic          en_q;
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic          h_in_sync, v_in_sync;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (en_q) begin
            if (h_q == CW'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + CW'(1);
            end else begin
                h_d = h_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= 1'b0;
            h_q  <= '0;
            v_q  <= '0;
        end else begin
            en_q <= ~en_q;
            h_q  <= h_d;
            v_q  <= v_d;
        end
    end

    assign h_in_sync = (h_q >= CW'(H_SYNC_LO)) && (h_q <= CW'(H_SYNC_HI));
    assign v_in_sync = (v_q >= CW'(V_SYNC_LO)) && (v_q <= CW'(V_SYNC_HI));

    // Decodes come straight off the counter flops; rst masks them in the same
    // cycle so a mid-frame reset drops the sync pulse without waiting an edge.
    assign vga.clk_en_25MHz = en_q & ~rst;
    assign vga.h_sync       = (h_in_sync && !rst) ? SYNC_POL : ~SYNC_POL;
    assign vga.v_sync       = (v_in_sync && !rst) ? SYNC_POL : ~SYNC_POL;
    assign vga.video_on     = !rst && (h_q < CW'(H_ACTIVE)) && (v_q < CW'(V_ACTIVE));
    assign vga.pixel_x      = rst ? '0 : h_q;
    assign vga.pixel_y      = rst ? '0 : v_q;
    assign vga.line_start   = !rst && en_q && (h_q == '0);
    assign vga.frame_start  = !rst && en_q && (h_q == '0) && (v_q == '0);
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line-level timing, and a tiny
// active-high-sync instance for full-frame, corner and mid-frame reset checks.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    vga_timing_if #(.CW(10)) ifa ();
    vga_timing_if #(.CW(10)) ifb ();

    vga_timing_gen #(.CW(10)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .vga (ifa.master)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .CW(10)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .vga (ifb.master)
    );

    // {en, h_sync, v_sync, video_on, line_start, frame_start, pixel_x, pixel_y}
    logic [25:0] act_a, act_b;
    assign act_a = {ifa.clk_en_25MHz, ifa.h_sync, ifa.v_sync, ifa.video_on,
                    ifa.line_start, ifa.frame_start, ifa.pixel_x, ifa.pixel_y};
    assign act_b = {ifb.clk_en_25MHz, ifb.h_sync, ifb.v_sync, ifb.video_on,
                    ifb.line_start, ifb.frame_start, ifb.pixel_x, ifb.pixel_y};

    localparam logic [25:0] RST_A = {6'b011000, 10'd0, 10'd0};
    localparam logic [25:0] RST_B = {6'b000000, 10'd0, 10'd0};

    int checks = 0;
    int errors = 0;

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (act_a !== RST_A) begin
                errors++;
                $display("FAIL reset_a cyc %0d: got %h expected %h", i, act_a, RST_A);
            end
            checks++;
            if (act_b !== RST_B) begin
                errors++;
                $display("FAIL reset_b cyc %0d: got %h expected %h", i, act_b, RST_B);
            end
        end
    endtask

    task automatic test_startup();
        logic [25:0] exp;
        logic        en, fs;
        @(posedge clk);
        #1 rst_a = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            en  = (c % 2 == 0);
            fs  = (c == 2);
            exp = {en, 1'b1, 1'b1, 1'b1, fs, fs, 10'((c - 1) / 2), 10'd0};
            checks++;
            if (act_a !== exp) begin
                errors++;
                $display("FAIL startup clk%0d: got %h expected %h", c, act_a, exp);
            end
        end
    endtask

    // Continues from startup clk4; cycle c has pixel_x = (c-1)/2 on line 0.
    task automatic test_line();
        logic       prev_hs, prev_vid;
        logic [9:0] prev_px;
        int fall_c = -1, rise_c = -1, ls_c = -1;
        logic [9:0] fall_px = '0, rise_px = '0, vfall_px = '0, vfall_prev = '0;
        prev_hs  = 1'b1;
        prev_vid = 1'b1;
        prev_px  = 10'd1;
        for (int c = 5; c <= 1700; c++) begin
            @(negedge clk);
            if (prev_hs && !ifa.h_sync) begin fall_c = c; fall_px = ifa.pixel_x; end
            if (!prev_hs && ifa.h_sync) begin rise_c = c; rise_px = ifa.pixel_x; end
            if (prev_vid && !ifa.video_on && ifa.pixel_y == 10'd0) begin
                vfall_px = ifa.pixel_x; vfall_prev = prev_px;
            end
            if (ifa.line_start && ls_c < 0) ls_c = c;
            prev_hs  = ifa.h_sync;
            prev_vid = ifa.video_on;
            prev_px  = ifa.pixel_x;
        end
        checks++;
        if (fall_px !== 10'd656 || fall_c != 1313) begin
            errors++;
            $display("FAIL hsync_fall: px %0d at clk %0d, expected 656 at 1313", fall_px, fall_c);
        end
        checks++;
        if (rise_px !== 10'd752) begin
            errors++;
            $display("FAIL hsync_rise_px: got %0d expected 752", rise_px);
        end
        checks++;
        if (rise_c - fall_c != 192) begin
            errors++;
            $display("FAIL hsync_width: got %0d expected 192", rise_c - fall_c);
        end
        checks++;
        if (vfall_px !== 10'd640 || vfall_prev !== 10'd639) begin
            errors++;
            $display("FAIL video_off: %0d->%0d expected 639->640", vfall_prev, vfall_px);
        end
        checks++;
        if (ls_c - 2 != 1600) begin
            errors++;
            $display("FAIL line_period: got %0d expected 1600", ls_c - 2);
        end
        checks++;
        if (ifa.pixel_y !== 10'd1 || ifa.v_sync !== 1'b1) begin
            errors++;
            $display("FAIL line1_row: py %0d vs %b expected 1/1", ifa.pixel_y, ifa.v_sync);
        end
    endtask

    task automatic test_reset_mid_line();
        logic [25:0] exp;
        bit found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (ifa.pixel_x == 10'd700) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_700: pixel_x never reached 700, got %0d", ifa.pixel_x);
            return;
        end
        checks++;
        if (ifa.h_sync !== 1'b0 || ifa.video_on !== 1'b0) begin
            errors++;
            $display("FAIL at_700: hs %b vid %b expected 0 0", ifa.h_sync, ifa.video_on);
        end
        rst_a = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (act_a !== RST_A) begin
                errors++;
                $display("FAIL mid_reset_a cyc %0d: got %h expected %h", i, act_a, RST_A);
            end
        end
        @(posedge clk);
        #1 rst_a = 1'b0;
        @(negedge clk);
        exp = {6'b011100, 10'd0, 10'd0};
        checks++;
        if (act_a !== exp) begin
            errors++;
            $display("FAIL restart_a clk1: got %h expected %h", act_a, exp);
        end
        @(negedge clk);
        exp = {6'b111111, 10'd0, 10'd0};
        checks++;
        if (act_a !== exp) begin
            errors++;
            $display("FAIL restart_a clk2: got %h expected %h", act_a, exp);
        end
    endtask

    // Small instance: line 14 px (28 clk), frame 7 lines (196 clk), h_sync at 10..11, v_sync at row 5.
    task automatic test_small_frames();
        logic [25:0] exp;
        int hc, h, v, fs_cnt = 0, fs_last = 0, fs_prev = 0, vs_cyc = 0, bad = 0;
        logic en, ls;
        @(posedge clk);
        #1 rst_b = 1'b0;
        for (int c = 1; c <= 420; c++) begin
            @(negedge clk);
            en  = (c % 2 == 0);
            hc  = (c - 1) / 2;
            h   = hc % 14;
            v   = (hc / 14) % 7;
            ls  = en && (h == 0);
            exp = {en, (h >= 10 && h <= 11), (v == 5), (h < 8 && v < 4),
                   ls, ls && (v == 0), 10'(h), 10'(v)};
            checks++;
            if (act_b !== exp) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL small_raster clk%0d: got %h expected %h", c, act_b, exp);
            end
            if (ifb.v_sync) vs_cyc++;
            if (ifb.frame_start) begin fs_cnt++; fs_prev = fs_last; fs_last = c; end
            if (c == 198) begin
                checks++;
                if (!(ifb.pixel_x == 0 && ifb.pixel_y == 0 && ifb.video_on &&
                      ifb.line_start && ifb.frame_start)) begin
                    errors++;
                    $display("FAIL corner_wrap: got %h expected (0,0) vid ls fs", act_b);
                end
            end
        end
        checks++;
        if (fs_cnt != 3 || fs_last - fs_prev != 196) begin
            errors++;
            $display("FAIL frame_period: %0d pulses spacing %0d expected 3 / 196", fs_cnt, fs_last - fs_prev);
        end
        checks++;
        if (vs_cyc != 56) begin
            errors++;
            $display("FAIL vsync_width: got %0d clk expected 56", vs_cyc);
        end
    endtask

    task automatic test_small_reset_mid();
        logic [25:0] exp;
        bit found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (ifb.pixel_x == 10'd10 && ifb.pixel_y == 10'd5) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_10_5: never reached, at (%0d,%0d)", ifb.pixel_x, ifb.pixel_y);
            return;
        end
        checks++;
        if (ifb.h_sync !== 1'b1 || ifb.v_sync !== 1'b1) begin
            errors++;
            $display("FAIL small_sync_pol: hs %b vs %b expected 1 1", ifb.h_sync, ifb.v_sync);
        end
        rst_b = 1'b1;
        #1;
        checks++;
        if (act_b !== RST_B) begin
            errors++;
            $display("FAIL mid_reset_b: got %h expected %h", act_b, RST_B);
        end
        @(posedge clk);
        #1 rst_b = 1'b0;
        @(negedge clk);
        exp = {6'b000100, 10'd0, 10'd0};
        checks++;
        if (act_b !== exp) begin
            errors++;
            $display("FAIL restart_b clk1: got %h expected %h", act_b, exp);
        end
        @(negedge clk);
        exp = {6'b100111, 10'd0, 10'd0};
        checks++;
        if (act_b !== exp) begin
            errors++;
            $display("FAIL restart_b clk2: got %h expected %h", act_b, exp);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_line();
        test_reset_mid_line();
        test_small_frames();
        test_small_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
